// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: computes a - b - bin one bit per cycle, LSB first,
// through a single full-subtractor stage driven by a three-state controller.
module serial_sub_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             br_q, br_d;
   logic             bout_q, bout_d;

   logic x, y, d_bit, br_nxt, last;

   always_comb begin
      x      = a_q[cnt_q];
      y      = b_q[cnt_q];
      d_bit  = x ^ y ^ br_q;
      br_nxt = (~(x ^ y) & br_q) | (~x & y);
      last   = (cnt_q == CW'(WIDTH - 1));
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      br_d    = br_q;
      bout_d  = bout_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               br_d    = bin;
               res_d   = '0;
               cnt_d   = '0;
               bout_d  = 1'b0;
               state_d = RUN;
            end
         end
         RUN: begin
            res_d[cnt_q] = d_bit;
            br_d         = br_nxt;
            // Counter parks on the MSB index rather than wrapping.
            if (last) begin
               bout_d  = br_nxt;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         br_q    <= 1'b0;
         bout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         br_q    <= br_d;
         bout_q  <= bout_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);
   assign diff = res_q;
   assign bout = bout_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed-vector and sequence bench for serial_sub_ctrl at WIDTH=8 and WIDTH=5.
module tb_serial_sub_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       st8 = 1'b0, st5 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic [4:0] a5 = '0, b5 = '0;
   logic       bin8 = 1'b0, bin5 = 1'b0;
   logic       busy8, done8, bout8, busy5, done5, bout5;
   logic [7:0] diff8;
   logic [4:0] diff5;

   int nchecks = 0, nerr = 0;
   int ndone8 = 0, ndone5 = 0, exp8 = 0, exp5 = 0;

   always #5 clk = ~clk;

   serial_sub_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8), .bin(bin8),
      .busy(busy8), .done(done8), .diff(diff8), .bout(bout8));

   serial_sub_ctrl #(.WIDTH(5)) dut5 (
      .clk(clk), .rst(rst), .start(st5), .a(a5), .b(b5), .bin(bin5),
      .busy(busy5), .done(done5), .diff(diff5), .bout(bout5));

   always @(posedge clk) begin
      if (done8) ndone8++;
      if (done5) ndone5++;
   end

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       bin;
      logic [7:0] diff;
      logic       bout;
   } vec_t;

   task automatic chk(input string nm, input int act, input int exp);
      nchecks++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // One complete operation on the selected instance; checks latency,
   // result, borrow and the single-cycle done pulse.
   task automatic run_op(input int w, input logic [7:0] av, input logic [7:0] bv,
                         input logic bi, input logic [7:0] ed, input logic eb,
                         input string nm);
      int  lat;
      bit  seen;
      lat  = 0;
      seen = 0;
      @(negedge clk);
      if (w == 8) begin a8 = av; b8 = bv; bin8 = bi; st8 = 1'b1; end
      else begin a5 = av[4:0]; b5 = bv[4:0]; bin5 = bi; st5 = 1'b1; end
      @(posedge clk); #1;
      st8 = 1'b0; st5 = 1'b0;
      a8 = ~av; b8 = ~bv; a5 = ~av[4:0]; b5 = ~bv[4:0];
      for (int i = 0; i < 40 && !seen; i++) begin
         @(posedge clk); #1;
         lat++;
         if ((w == 8) ? done8 : done5) seen = 1;
      end
      if (!seen) begin
         chk({nm, " timeout"}, 0, 1);
         return;
      end
      if (w == 8) exp8++; else exp5++;
      chk({nm, " latency"}, lat, w);
      chk({nm, " diff"}, (w == 8) ? int'(diff8) : int'(diff5), int'(ed));
      chk({nm, " bout"}, (w == 8) ? int'(bout8) : int'(bout5), int'(eb));
      chk({nm, " busy_in_done"}, (w == 8) ? int'(busy8) : int'(busy5), 1);
      @(posedge clk); #1;
      chk({nm, " done_width"}, (w == 8) ? int'(done8) : int'(done5), 0);
      chk({nm, " idle_after"}, (w == 8) ? int'(busy8) : int'(busy5), 0);
   endtask

   vec_t vecs[8];

   initial begin
      int lat, d1, d2, cyc;
      bit seen;
      logic [7:0] ra, rb, rd;
      logic       rbi, rbo;
      int full;

      vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
      vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
      vecs[2] = '{8'h80, 8'h80, 1'b1, 8'hFF, 1'b1};
      vecs[3] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
      vecs[4] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0};
      vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      vecs[6] = '{8'h37, 8'h12, 1'b1, 8'h24, 1'b0};
      vecs[7] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};

      #1;
      chk("rst busy", busy8, 0);
      chk("rst done", done8, 0);
      chk("rst diff", diff8, 0);
      chk("rst bout", bout8, 0);
      #12 rst = 1'b0;

      foreach (vecs[i])
         run_op(8, vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].diff, vecs[i].bout,
                $sformatf("vec%0d", i));

      // Start pulsed mid-RUN with new operands must be ignored.
      @(negedge clk);
      a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b0; st8 = 1'b1;
      @(posedge clk); #1;
      st8 = 1'b0;
      lat = 0; seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(posedge clk); #1;
         lat++;
         if (lat == 3) begin a8 = 8'h01; b8 = 8'h01; bin8 = 1'b1; st8 = 1'b1; end
         if (lat == 4) st8 = 1'b0;
         if (done8) seen = 1;
      end
      chk("ignore seen", seen, 1);
      if (seen) exp8++;
      chk("ignore latency", lat, 8);
      chk("ignore diff", diff8, 8'hFF);
      chk("ignore bout", bout8, 0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("ignore not_queued", busy8, 0);
      end
      chk("hold diff", diff8, 8'hFF);

      // Asynchronous reset during RUN.
      @(negedge clk);
      a8 = 8'h77; b8 = 8'h11; bin8 = 1'b0; st8 = 1'b1;
      @(posedge clk); #1;
      st8 = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort busy", busy8, 0);
      chk("abort done", done8, 0);
      chk("abort diff", diff8, 0);
      chk("abort bout", bout8, 0);
      @(negedge clk); rst = 1'b0;
      run_op(8, 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, "post_rst");

      // start held high: accept-to-accept spacing is WIDTH+2.
      @(negedge clk);
      a8 = 8'h03; b8 = 8'h01; bin8 = 1'b0; st8 = 1'b1;
      d1 = -1; d2 = -1; cyc = 0;
      for (int i = 0; i < 60 && d2 < 0; i++) begin
         @(posedge clk); #1;
         cyc++;
         if (done8) begin
            if (d1 < 0) d1 = cyc; else begin d2 = cyc; st8 = 1'b0; end
         end
      end
      st8 = 1'b0;
      chk("b2b seen", (d2 >= 0) ? 1 : 0, 1);
      if (d1 >= 0) exp8++;
      if (d2 >= 0) exp8++;
      chk("b2b period", d2 - d1, 10);
      chk("b2b diff", diff8, 8'h02);
      repeat (3) @(posedge clk);

      for (int i = 0; i < 1000; i++) begin
         ra  = 8'($urandom_range(0, 255));
         rb  = 8'($urandom_range(0, 255));
         rbi = 1'($urandom_range(0, 1));
         full = int'(ra) - int'(rb) - int'(rbi);
         rd  = 8'(full);
         rbo = (full < 0);
         run_op(8, ra, rb, rbi, rd, rbo, "rand8");
      end
      for (int i = 0; i < 1000; i++) begin
         ra  = 8'($urandom_range(0, 31));
         rb  = 8'($urandom_range(0, 31));
         rbi = 1'($urandom_range(0, 1));
         full = int'(ra) - int'(rb) - int'(rbi);
         rd  = 8'(full & 31);
         rbo = (full < 0);
         run_op(5, ra, rb, rbi, rd, rbo, "rand5");
      end

      repeat (2) @(posedge clk); #1;
      chk("done_count8", ndone8, exp8);
      chk("done_count5", ndone5, exp5);

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
      $finish;
   end

endmodule
